// File: rtl/ram_pkg.sv
// Shared constants, FSM state type and width helper for the RAM line controller.
package ram_pkg;

   localparam int unsigned WORD_SIZE = 32;
   localparam int unsigned BURST_LEN = 4;
   localparam int unsigned LINE_SIZE = BURST_LEN * WORD_SIZE;

   function automatic int unsigned beat_cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RBURST,
      WBURST,
      DONE
   } ram_state_e;

endpackage

// File: rtl/ram_line_store.sv
// Word-organised line storage with one synchronous read/write port addressed by {line, beat}.
module ram_line_store #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 32
) (
   input  logic          i_clk,
   input  logic          i_nreset,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   // Contents are deliberately not reset; only the read register is.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_line_ctrl.sv
// Line-burst RAM controller: one request moves a line as BURST_LEN words after LATENCY waits.
// Define RAM_STATS_EN to add saturating read/write transaction counters.
module ram_line_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned ADDR_SIZE        = 14,
   parameter int unsigned LINE_DEPTH_WIDTH = 8,
   parameter int unsigned LATENCY          = 3
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic                 ram_aval,
   input  logic                 ram_rnw,
   input  logic [ADDR_SIZE-1:0] ram_addr,
   input  logic [WORD_SIZE-1:0] ram_wdata,
   output logic                 ram_ready,
   output logic [WORD_SIZE-1:0] ram_rdata,
   output logic                 ram_ack,
   output logic                 ram_done
`ifdef RAM_STATS_EN
   ,
   output logic [15:0]          stat_rd_cnt,
   output logic [15:0]          stat_wr_cnt
`endif
);

   localparam int unsigned BEAT_W = beat_cnt_w(LINE_SIZE / WORD_SIZE);
   localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned MEM_AW = LINE_DEPTH_WIDTH + BEAT_W;

   ram_state_e                  r_state, w_state_nxt;
   logic                        r_rnw;
   logic [LINE_DEPTH_WIDTH-1:0] r_line;
   logic [LAT_W-1:0]            r_lat;
   logic [BEAT_W-1:0]           r_beat;
   logic                        r_ack;
   logic                        r_done;
   logic                        w_accept;
   logic                        w_last_beat;
   logic                        w_mem_we;
   logic                        w_mem_re;
   logic                        w_unused_addr;

   // Upper address bits alias onto the stored lines.
   assign w_unused_addr = ^ram_addr[ADDR_SIZE-1:LINE_DEPTH_WIDTH];

   assign w_accept    = (r_state == IDLE) && ram_aval;
   assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      unique case (r_state)
         IDLE:   if (ram_aval) w_state_nxt = WAIT;
         WAIT:   if (r_lat == '0) w_state_nxt = r_rnw ? RBURST : WBURST;
         RBURST: begin
            w_mem_re = 1'b1;
            if (w_last_beat) w_state_nxt = DONE;
         end
         WBURST: begin
            w_mem_we = 1'b1;
            if (w_last_beat) w_state_nxt = DONE;
         end
         DONE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_state <= IDLE;
         r_rnw   <= 1'b0;
         r_line  <= '0;
         r_lat   <= '0;
         r_beat  <= '0;
         r_ack   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Ack and done are registered so ack lines up with the registered read word.
         r_ack   <= w_mem_re || w_mem_we;
         r_done  <= (r_state == DONE);
         if (w_accept) begin
            r_rnw  <= ram_rnw;
            r_line <= ram_addr[LINE_DEPTH_WIDTH-1:0];
            r_lat  <= LAT_W'(LATENCY - 1);
         end
         if (r_state == WAIT) begin
            r_beat <= '0;
            if (r_lat != '0) r_lat <= r_lat - LAT_W'(1);
         end
         if (w_mem_re || w_mem_we) begin
            r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
         end
      end
   end

   ram_line_store #(
      .AW (MEM_AW),
      .DW (WORD_SIZE)
   ) u_store (
      .i_clk    (clk),
      .i_nreset (nReset),
      .i_we     (w_mem_we),
      .i_re     (w_mem_re),
      .i_addr   ({r_line, r_beat}),
      .i_wdata  (ram_wdata),
      .o_rdata  (ram_rdata)
   );

   assign ram_ready = (r_state == IDLE);
   assign ram_ack   = r_ack;
   assign ram_done  = r_done;

`ifdef RAM_STATS_EN
   logic [15:0] r_rd_cnt, r_wr_cnt;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else if (r_state == DONE) begin
         if (r_rnw && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
         if (!r_rnw && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
      end
   end

   assign stat_rd_cnt = r_rd_cnt;
   assign stat_wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_ram_line_ctrl.sv
// Directed bench for ram_line_ctrl (LATENCY=3, BURST_LEN=4); stats checks only with RAM_STATS_EN.
module tb_ram_line_ctrl;

   logic        clk = 1'b0;
   logic        nReset;
   logic        ram_aval;
   logic        ram_rnw;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_ready;
   logic [31:0] ram_rdata;
   logic        ram_ack;
   logic        ram_done;
`ifdef RAM_STATS_EN
   logic [15:0] stat_rd_cnt;
   logic [15:0] stat_wr_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] wd [4];
   logic [31:0] rd [4];
   int          n_ack, lat_first, lat_done, acc_cyc;
   logic        rdy_at_done;

   ram_line_ctrl #(
      .ADDR_SIZE        (14),
      .LINE_DEPTH_WIDTH (8),
      .LATENCY          (3)
   ) dut (
      .clk       (clk),
      .nReset    (nReset),
      .ram_aval  (ram_aval),
      .ram_rnw   (ram_rnw),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_ready (ram_ready),
      .ram_rdata (ram_rdata),
      .ram_ack   (ram_ack),
      .ram_done  (ram_done)
`ifdef RAM_STATS_EN
      ,
      .stat_rd_cnt (stat_rd_cnt),
      .stat_wr_cnt (stat_wr_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic check_rst_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(ram_ready), 32'd1);
      check_eq({tag, "_ack"},   32'(ram_ack),   32'd0);
      check_eq({tag, "_done"},  32'(ram_done),  32'd0);
      check_eq({tag, "_rdata"}, ram_rdata,      32'd0);
   endtask

   // Called at a negedge. Runs one transaction and returns at the ram_done negedge
   // (or after the reset abort when abort_after beats have been acked).
   task automatic xfer(input logic rnw, input logic [13:0] addr, input bit hold,
                       input bit pulse, input int abort_after);
      int t;
      bit fin;
      ram_aval    = 1'b1;
      ram_rnw     = rnw;
      ram_addr    = addr;
      ram_wdata   = wd[0];
      n_ack       = 0;
      lat_first   = -1;
      lat_done    = -1;
      rdy_at_done = 1'b0;
      t = 0;
      while (!ram_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!ram_ready) begin
         check_eq("accept_timeout", 32'(ram_ready), 32'd1);
         ram_aval = 1'b0;
         return;
      end
      acc_cyc = cyc + 1;
      fin = 1'b0;
      for (int i = 0; i < 30 && !fin; i++) begin
         @(negedge clk);
         if (!hold) ram_aval = pulse && ((cyc == acc_cyc + 1) || (cyc == acc_cyc + 5));
         if (ram_ack) begin
            if (n_ack == 0) lat_first = cyc - acc_cyc;
            if (n_ack < 4) rd[n_ack] = ram_rdata;
            n_ack++;
            if (n_ack < 4) ram_wdata = wd[n_ack];
            if (abort_after != 0 && n_ack == abort_after) begin
               nReset   = 1'b0;
               ram_aval = 1'b0;
               #1;
               check_rst_outputs("abort_rst");
               @(negedge clk);
               @(negedge clk);
               nReset = 1'b1;
               fin = 1'b1;
            end
         end
         if (!fin && ram_done) begin
            lat_done    = cyc - acc_cyc;
            rdy_at_done = ram_ready;
            fin = 1'b1;
         end
      end
      if (!fin) check_eq("done_timeout", 32'(ram_done), 32'd1);
   endtask

   initial begin
      int done_abs, extra_ack, not_ready;
      nReset    = 1'b0;
      ram_aval  = 1'b0;
      ram_rnw   = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      repeat (2) @(negedge clk);
      check_rst_outputs("rst");
      nReset = 1'b1;
      @(negedge clk);

      // 1: write line 0x005
      wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      xfer(1'b0, 14'h005, 1'b0, 1'b0, 0);
      check_eq("t1_acks", n_ack, 4);
      check_eq("t1_first_ack", lat_first, 4);
      check_eq("t1_done", lat_done, 8);
      check_eq("t1_ready", 32'(rdy_at_done), 32'd1);

      // 2: read it back
      xfer(1'b1, 14'h005, 1'b0, 1'b0, 0);
      check_eq("t2_acks", n_ack, 4);
      check_eq("t2_first_ack", lat_first, 4);
      check_eq("t2_d0", rd[0], 32'h11111111);
      check_eq("t2_d1", rd[1], 32'h22222222);
      check_eq("t2_d2", rd[2], 32'h33333333);
      check_eq("t2_d3", rd[3], 32'h44444444);
      check_eq("t2_done", lat_done, 8);

      // 3: aval held, back-to-back reads of 0x005 and its alias 0x105
      xfer(1'b1, 14'h005, 1'b1, 1'b0, 0);
      done_abs = cyc;
      check_eq("t3a_acks", n_ack, 4);
      xfer(1'b1, 14'h105, 1'b1, 1'b0, 0);
      ram_aval = 1'b0;
      check_eq("t3_accept_gap", acc_cyc - done_abs, 1);
      check_eq("t3b_acks", n_ack, 4);
      check_eq("t3b_first_ack", lat_first, 4);
      check_eq("t3b_d0", rd[0], 32'h11111111);
      check_eq("t3b_d3", rd[3], 32'h44444444);

      // 4: reset after 2nd beat of a write over an AAAAAAAA line
      wd = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA};
      xfer(1'b0, 14'h010, 1'b0, 1'b0, 0);
      wd = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
      xfer(1'b0, 14'h010, 1'b0, 1'b0, 2);
      check_eq("t4_acks_before_rst", n_ack, 2);
      xfer(1'b1, 14'h010, 1'b0, 1'b0, 0);
      check_eq("t4_d0", rd[0], 32'h00000001);
      check_eq("t4_d1", rd[1], 32'h00000002);
      check_eq("t4_d2", rd[2], 32'hAAAAAAAA);
      check_eq("t4_d3", rd[3], 32'hAAAAAAAA);

      // 5: aval pulses during WAIT and RBURST must not add beats or queue
      xfer(1'b1, 14'h005, 1'b0, 1'b1, 0);
      check_eq("t5_acks", n_ack, 4);
      check_eq("t5_done", lat_done, 8);
      check_eq("t5_d1", rd[1], 32'h22222222);
      extra_ack = 0;
      not_ready = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ram_ack) extra_ack++;
         if (!ram_ready) not_ready++;
      end
      check_eq("t5_extra_acks", extra_ack, 0);
      check_eq("t5_not_ready", not_ready, 0);

`ifdef RAM_STATS_EN
      // 6: transaction counters
      nReset = 1'b0;
      #1;
      check_eq("t6_rst_rd", 32'(stat_rd_cnt), 32'd0);
      check_eq("t6_rst_wr", 32'(stat_wr_cnt), 32'd0);
      @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      wd = '{32'h5, 32'h6, 32'h7, 32'h8};
      for (int i = 0; i < 3; i++) xfer(1'b0, 14'h020, 1'b0, 1'b0, 0);
      for (int i = 0; i < 2; i++) xfer(1'b1, 14'h020, 1'b0, 1'b0, 0);
      @(negedge clk);
      check_eq("t6_wr_cnt", 32'(stat_wr_cnt), 32'd3);
      check_eq("t6_rd_cnt", 32'(stat_rd_cnt), 32'd2);
      nReset = 1'b0;
      #1;
      check_eq("t6_rst2_rd", 32'(stat_rd_cnt), 32'd0);
      check_eq("t6_rst2_wr", 32'(stat_wr_cnt), 32'd0);
      @(negedge clk);
      nReset = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
